// File: rtl/fifo_reader_pkg.sv
// Shared types and default widths for the FIFO read-side burst engine.
package fifo_reader_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 4;
  localparam int unsigned RD_CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// Small circular output buffer between the FIFO read port and the stream.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 3,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clr,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (occ != '0);
  assign do_push = push && ((occ != OCC_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side engine: groups pops into bursts and re-presents words on a
// valid/ready stream through a credit-limited buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned BUF_DEPTH = 3
)(
  input  logic                clk,
  input  logic                rst,
  output logic                fifo_rd_en,
  input  logic [DATA_W-1:0]   fifo_data_o,
  input  logic                fifo_empty,
  input  logic [CNT_W-1:0]    fifo_cnt,
  input  logic                flush,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                burst_active,
  output logic [RD_CNT_W-1:0] rd_count
);

  localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CRED_W = OCC_W + 1;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  burst_left;
  logic              inflight;
  logic [OCC_W-1:0]  buf_occ;
  logic [CRED_W-1:0] credit_used;
  logic              xfer;

  // Credit counts words already buffered plus the one still on the FIFO read
  // port; both are registered so stream ready never reaches the pop strobe.
  assign credit_used = {1'b0, buf_occ} + CRED_W'(inflight);
  assign fifo_rd_en  = (state == BURST) && !fifo_empty
                    && (credit_used < CRED_W'(BUF_DEPTH))
                    && (burst_left != '0) && !flush;
  assign m_valid     = (buf_occ != '0);
  assign xfer        = m_valid && m_ready;

  fifo_reader_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data_o),
    .pop       (xfer),
    .clr       (flush),
    .occ       (buf_occ),
    .head      (m_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      burst_active <= 1'b0;
      timer        <= '0;
      burst_left   <= '0;
      inflight     <= 1'b0;
      rd_count     <= '0;
    end else if (flush) begin
      // A word handed over in the flush cycle is dropped with the rest, so
      // the delivered count is left untouched.
      state        <= IDLE;
      burst_active <= 1'b0;
      timer        <= '0;
      burst_left   <= '0;
      inflight     <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (xfer) rd_count <= rd_count + RD_CNT_W'(1);
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state <= WAIT;
            timer <= '0;
          end
        end
        WAIT: begin
          if (fifo_cnt >= CNT_W'(BURST_LEN)) begin
            state        <= BURST;
            burst_active <= 1'b1;
            burst_left   <= CNT_W'(BURST_LEN);
          end else if (timer == TMR_W'(TIMEOUT)) begin
            state        <= BURST;
            burst_active <= 1'b1;
            burst_left   <= fifo_cnt;
          end else if (fifo_empty) begin
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        BURST: begin
          if (fifo_rd_en) begin
            burst_left <= burst_left - CNT_W'(1);
            if (burst_left == CNT_W'(1)) begin
              state        <= IDLE;
              burst_active <= 1'b0;
            end
          end else if (fifo_empty || (burst_left == '0)) begin
            state        <= IDLE;
            burst_active <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          burst_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: bench-side FIFO, stream scoreboard and directed timing checks.
module tb_fifo_reader;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data_o = '0;
  logic        fifo_empty = 1'b1;
  logic [3:0]  fifo_cnt = '0;
  logic        flush = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        burst_active;
  logic [15:0] rd_count;

  fifo_reader #(
    .DATA_W    (8),
    .CNT_W     (4),
    .BURST_LEN (BL),
    .TIMEOUT   (15),
    .BUF_DEPTH (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_data_o  (fifo_data_o),
    .fifo_empty   (fifo_empty),
    .fifo_cnt     (fifo_cnt),
    .flush        (flush),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .burst_active (burst_active),
    .rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  fq[$];     // bench FIFO contents
  logic [7:0]  pre_q[$];  // words to load into the FIFO at the next step
  logic [7:0]  sb[$];     // words the stream buffer must hold, oldest first
  logic [7:0]  got[$];
  logic        pop_pend = 1'b0;
  logic        m_infl = 1'b0;
  logic [15:0] m_cnt = '0;
  logic        nx_ready = 1'b0;
  logic        nx_flush = 1'b0;
  logic        chk_en = 1'b0;
  int          brd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench FIFO: a pop seen at a clock edge presents its word for the next cycle.
  always @(negedge clk) begin
    #1;
    if (pop_pend && fq.size() != 0) fifo_data_o = fq.pop_front();
    fifo_cnt   = 4'(fq.size());
    fifo_empty = (fq.size() == 0);
  end

  // Reference model of what the stream must show, advanced at each edge.
  always @(posedge clk) begin
    if (!rst) begin
      sb.delete();
      m_infl   = 1'b0;
      m_cnt    = '0;
      pop_pend = 1'b0;
    end else begin
      pop_pend = fifo_rd_en;
      if (flush) begin
        sb.delete();
        m_infl = 1'b0;
      end else begin
        if (sb.size() != 0 && m_ready) begin
          void'(sb.pop_front());
          m_cnt++;
        end
        if (m_infl) sb.push_back(fifo_data_o);
        m_infl = fifo_rd_en;
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    #2;
    if (rst && chk_en) begin
      check("m_valid", m_valid, sb.size() != 0);
      if (sb.size() != 0) check("m_data", m_data, sb[0]);
      check("rd_count", rd_count, m_cnt);
      if (fifo_rd_en) begin
        check("rd_while_empty", fifo_empty, 0);
        check("rd_outside_burst", burst_active, 1);
        check("rd_credit", (sb.size() + m_infl) < 3, 1);
        brd++;
        check("burst_len_limit", brd <= BL, 1);
      end
      if (!burst_active) brd = 0;
    end
  end

  task automatic step();
    @(negedge clk);
    m_ready = nx_ready;
    flush   = nx_flush;
    while (pre_q.size() != 0 && fq.size() < 15) fq.push_back(pre_q.pop_front());
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    fq.delete();
    pre_q.delete();
    nx_ready = 1'b0;
    nx_flush = 1'b0;
    m_ready  = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic collect(input int ncyc);
    got.delete();
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (m_valid && m_ready && !flush) got.push_back(m_data);
    end
  endtask

  initial begin
    int first_rd;
    int first_v;
    int nrd;
    int nba;

    // Reset state
    #2;
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_burst_active", burst_active, 0);
    check("reset_rd_count", rd_count, 0);
    do_reset();
    chk_en = 1'b1;

    // Full burst
    nx_ready = 1'b1;
    for (int k = 0; k < 8; k++) pre_q.push_back(8'(8'h10 + k));
    first_rd = -1; first_v = -1; nrd = 0; nba = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fifo_rd_en) begin nrd++; if (first_rd < 0) first_rd = i; end
      if (burst_active) nba++;
      if (m_valid && first_v < 0) first_v = i;
      if (i >= 4) begin
        check("full_valid", m_valid, 1);
        check("full_data", m_data, 32'h10 + i - 4);
      end
    end
    check("full_nrd", nrd, 4);
    check("full_burst_cycles", nba, 4);
    check("full_first_rd", first_rd, 2);
    check("full_first_valid", first_v, 4);
    step();
    check("full_rd_count", rd_count, 4);
    repeat (20) step();
    check("full_drain_count", rd_count, 8);

    // Timeout partial burst
    do_reset();
    nx_ready = 1'b1;
    pre_q.push_back(8'hA5);
    pre_q.push_back(8'h5A);
    first_rd = -1; nrd = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (fifo_rd_en) begin nrd++; if (first_rd < 0) first_rd = i; end
      if (i == 19) begin
        check("to_data0", m_data, 8'hA5);
        check("to_idle", burst_active, 0);
      end
      if (i == 20) check("to_data1", m_data, 8'h5A);
    end
    check("to_first_rd", first_rd, 17);
    check("to_nrd", nrd, 2);
    check("to_rd_count", rd_count, 2);

    // Backpressure
    do_reset();
    nx_ready = 1'b0;
    for (int k = 0; k < 8; k++) pre_q.push_back(8'(8'h30 + k));
    nrd = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (fifo_rd_en) nrd++;
      if (i == 4 || i == 8 || i == 11) begin
        check("bp_valid", m_valid, 1);
        check("bp_hold", m_data, 8'h30);
      end
    end
    check("bp_nrd", nrd, 3);
    nx_ready = 1'b1;
    collect(40);
    check("bp_words", got.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < got.size()) check("bp_order", got[k], 32'h30 + k);
    check("bp_rd_count", rd_count, 8);

    // Flush with a read in flight
    do_reset();
    nx_ready = 1'b0;
    for (int k = 0; k < 8; k++) pre_q.push_back(8'(8'h50 + k));
    repeat (3) step();
    check("fl_rd_before", fifo_rd_en, 1);
    nx_flush = 1'b1;
    step();
    check("fl_rd_gated", fifo_rd_en, 0);
    nx_flush = 1'b0;
    nx_ready = 1'b1;
    step();
    check("fl_valid", m_valid, 0);
    check("fl_rd_count", rd_count, 0);
    collect(40);
    check("fl_words", got.size(), 7);
    if (got.size() != 0) check("fl_first_word", got[0], 8'h51);
    check("fl_final_count", rd_count, 7);

    // Asynchronous reset in the middle of a burst
    do_reset();
    nx_ready = 1'b1;
    for (int k = 0; k < 8; k++) pre_q.push_back(8'(8'h70 + k));
    repeat (6) step();
    check("mr_rd_pre", fifo_rd_en, 1);
    check("mr_count_pre", rd_count, 1);
    rst = 1'b0;
    #1;
    check("mr_rd_en", fifo_rd_en, 0);
    check("mr_valid", m_valid, 0);
    check("mr_data", m_data, 0);
    check("mr_burst", burst_active, 0);
    check("mr_count", rd_count, 0);
    @(negedge clk);
    fq.delete();
    @(negedge clk);
    rst = 1'b1;
    step();
    check("mr_idle", burst_active, 0);
    check("mr_count_after", rd_count, 0);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 3000; i++) begin
      nx_ready = ($urandom_range(0, 9) < 7);
      nx_flush = ($urandom_range(0, 49) == 0);
      if (pre_q.size() == 0 && $urandom_range(0, 1) == 1) pre_q.push_back(8'($urandom));
      step();
    end
    nx_ready = 1'b1;
    nx_flush = 1'b0;
    repeat (100) step();
    check("rand_fifo_drained", fq.size(), 0);
    check("rand_stream_idle", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
